// File: rtl/wb_xbar_pkg.sv
// rtl/wb_xbar_pkg.sv - shared state encoding, default address map and helpers for wb_xbar_arb
package wb_xbar_pkg;

  localparam logic [31:0] SRAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] APB_BASE    = 32'h1000_0000;
  localparam logic [31:0] DBG_BASE    = 32'h2000_0000;
  localparam logic [31:0] REGION_MASK = 32'hF000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_ERR  = ERR;

  // Index width that never collapses to zero bits, so a single master still has a 1-bit id.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - combinational NM-way fixed-priority / round-robin grant picker
module wb_rr_arbiter #(
  parameter int NM = 2,
  parameter int GW = 1,
  parameter bit RR = 1'b0
) (
  input  logic [NM-1:0] req_i,
  input  logic [GW-1:0] ptr_i,
  output logic [NM-1:0] gnt_oh_o,
  output logic [GW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  logic found;

  // First pass only looks at indices at or above the pointer; the second wraps to the bottom.
  always_comb begin
    found     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (!found && req_i[i] && (!RR || i >= int'(ptr_i))) begin
        found       = 1'b1;
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = GW'(i);
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (!found && req_i[i]) begin
        found       = 1'b1;
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = GW'(i);
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/wb_xbar_arb.sv
// rtl/wb_xbar_arb.sv - shared-bus Wishbone interconnect with locked grant, address decode and error responses
module wb_xbar_arb
  import wb_xbar_pkg::*;
#(
  parameter int               AW       = 32,
  parameter int               DW       = 32,
  parameter int               NM       = 2,
  parameter int               NS       = 3,
  parameter logic [NS*AW-1:0] SLV_BASE = {DBG_BASE, APB_BASE, SRAM_BASE},
  parameter logic [NS*AW-1:0] SLV_MASK = {3{REGION_MASK}},
  parameter bit               ARB_RR   = 1'b0,
  parameter int               TIMEOUT  = 255,
  localparam int              GW       = clog2_min1(NM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NM-1:0]    m_cyc,
  input  logic [NM-1:0]    m_stb,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_adr,
  input  logic [NM*DW-1:0] m_wdata,
  output logic [NM*DW-1:0] m_rdata,
  output logic [NM-1:0]    m_ack,
  output logic [NM-1:0]    m_err,
  output logic [NS-1:0]    s_cyc,
  output logic [NS-1:0]    s_stb,
  output logic [NS-1:0]    s_we,
  output logic [NS*AW-1:0] s_adr,
  output logic [NS*DW-1:0] s_wdata,
  input  logic [NS*DW-1:0] s_rdata,
  input  logic [NS-1:0]    s_ack,
  output logic [GW-1:0]    gnt_id,
  output logic             busy
);

  localparam int TW = clog2_min1(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [NM-1:0] arb_oh;
  logic [GW-1:0] arb_idx;
  logic          arb_valid;

  wb_rr_arbiter #(.NM(NM), .GW(GW), .RR(ARB_RR)) u_arb (
    .req_i       (m_cyc),
    .ptr_i       (rr_ptr_q),
    .gnt_oh_o    (arb_oh),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  logic          g_cyc, g_stb, g_we;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_wdata;

  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_adr   = '0;
    g_wdata = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q == GW'(i)) begin
        g_cyc   = m_cyc[i];
        g_stb   = m_stb[i];
        g_we    = m_we[i];
        g_adr   = m_adr[i*AW +: AW];
        g_wdata = m_wdata[i*DW +: DW];
      end
    end
  end

  logic [NS-1:0] hit_oh;
  logic          hit_any;
  logic          sel_ack;
  logic [DW-1:0] sel_rdata;

  always_comb begin
    hit_oh    = '0;
    hit_any   = 1'b0;
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (!hit_any && ((g_adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
        hit_oh[i] = 1'b1;
        hit_any   = 1'b1;
        sel_ack   = s_ack[i];
        sel_rdata = s_rdata[i*DW +: DW];
      end
    end
  end

  // Routing drops in the same cycle the granted master releases cyc.
  logic active;
  assign active = (state_q == ST_BUSY) && g_cyc;

  always_comb begin
    s_cyc   = '0;
    s_stb   = '0;
    s_we    = '0;
    s_adr   = '0;
    s_wdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (active && hit_oh[i]) begin
        s_cyc[i]             = 1'b1;
        s_stb[i]             = g_stb;
        s_we[i]              = g_we;
        s_adr[i*AW +: AW]    = g_adr;
        s_wdata[i*DW +: DW]  = g_wdata;
      end
    end
  end

  always_comb begin
    m_ack   = '0;
    m_err   = '0;
    m_rdata = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q == GW'(i)) begin
        m_ack[i] = active && sel_ack;
        m_err[i] = (state_q == ST_ERR);
        if (active) m_rdata[i*DW +: DW] = sel_rdata;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    tmo_d    = tmo_q;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (arb_valid) begin
          state_d  = ST_BUSY;
          gnt_d    = arb_idx;
          rr_ptr_d = arb_oh[NM-1] ? '0 : arb_idx + 1'b1;
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else if (g_stb && !hit_any) begin
          state_d = ST_ERR;
          tmo_d   = '0;
        end else if (!g_stb || sel_ack) begin
          tmo_d = '0;
        end else if (TIMEOUT != 0) begin
          if ((tmo_q + 1'b1) == TW'(TIMEOUT)) begin
            state_d = ST_ERR;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      ST_ERR: begin
        tmo_d   = '0;
        state_d = g_cyc ? ST_BUSY : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      tmo_q    <= tmo_d;
    end
  end

  assign gnt_id = gnt_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_xbar_arb.sv
// tb/tb_wb_xbar_arb.sv - directed self-checking bench for wb_xbar_arb (fixed and round-robin instances)
module tb_wb_xbar_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_adr, m_wdata;
  logic [95:0] s_rdata;
  logic [2:0]  s_ack;

  logic [63:0] d_m_rdata, r_m_rdata;
  logic [1:0]  d_m_ack, d_m_err, r_m_ack, r_m_err;
  logic [2:0]  d_s_cyc, d_s_stb, d_s_we, r_s_cyc, r_s_stb, r_s_we;
  logic [95:0] d_s_adr, d_s_wdata, r_s_adr, r_s_wdata;
  logic [0:0]  d_gnt_id, r_gnt_id;
  logic        d_busy, r_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_xbar_arb #(.ARB_RR(1'b0), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_rdata(d_m_rdata), .m_ack(d_m_ack), .m_err(d_m_err),
    .s_cyc(d_s_cyc), .s_stb(d_s_stb), .s_we(d_s_we), .s_adr(d_s_adr), .s_wdata(d_s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .gnt_id(d_gnt_id), .busy(d_busy)
  );

  wb_xbar_arb #(.ARB_RR(1'b1), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_rdata(r_m_rdata), .m_ack(r_m_ack), .m_err(r_m_err),
    .s_cyc(r_s_cyc), .s_stb(r_s_stb), .s_we(r_s_we), .s_adr(r_s_adr), .s_wdata(r_s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .gnt_id(r_gnt_id), .busy(r_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_wdata = '0;
    s_rdata = '0; s_ack = '0;
    #2;
    chk("rst_busy", d_busy, 0);
    chk("rst_gnt", d_gnt_id, 0);
    chk("rst_s_cyc", d_s_cyc, 0);
    chk("rst_m_resp", {d_m_err, d_m_ack}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Arbitration: both masters request every round
    s_ack = 3'b001; s_rdata[31:0] = 32'h1234_5678; m_adr = '0;
    for (int k = 0; k < 8; k++) begin
      m_cyc = 2'b11; m_stb = 2'b11;
      tick();
      chk("fix_gnt", d_gnt_id, 0);
      chk("fix_ack", d_m_ack, 2'b01);
      chk("rr_gnt", r_gnt_id, k % 2);
      chk("rr_ack", r_m_ack, (k % 2 == 1) ? 2'b10 : 2'b01);
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
    end
    s_ack = '0;

    // Single SRAM read by m0
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00; m_adr = 64'h10;
    #1;
    chk("t1_idle_stb", d_s_stb, 0);
    tick();
    chk("t1_gnt", d_gnt_id, 0);
    chk("t1_busy", d_busy, 1);
    chk("t1_s_stb", d_s_stb, 3'b001);
    chk("t1_s_cyc", d_s_cyc, 3'b001);
    chk("t1_no_ack", d_m_ack, 0);
    tick();
    chk("t1_wait_ack", d_m_ack, 0);
    s_ack = 3'b001; s_rdata[31:0] = 32'hDEAD_BEEF;
    #1;
    chk("t1_ack", d_m_ack, 2'b01);
    chk("t1_rdata", d_m_rdata, 64'h0000_0000_DEAD_BEEF);
    tick();
    s_ack = '0; m_cyc = '0; m_stb = '0;
    #1;
    chk("t1_drop_s_cyc", d_s_cyc, 0);
    chk("t1_still_busy", d_busy, 1);
    tick();
    chk("t1_idle", d_busy, 0);

    // m1 write stalls behind m0
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b10;
    m_adr = {32'h1000_0004, 32'h0000_0010}; m_wdata = {32'h0000_0055, 32'h0};
    tick();
    chk("t3_gnt0", d_gnt_id, 0);
    chk("t3_s_stb0", d_s_stb, 3'b001);
    tick();
    tick();
    chk("t3_m1_stall", d_m_ack, 0);
    chk("t3_no_we", d_s_we, 0);
    m_cyc = 2'b10; m_stb = 2'b10;
    #1;
    chk("t3_drop", d_s_cyc, 0);
    tick();
    chk("t3_idle_gap", d_busy, 0);
    tick();
    chk("t3_gnt1", d_gnt_id, 1);
    chk("t3_s_stb1", d_s_stb, 3'b010);
    chk("t3_s_we", d_s_we, 3'b010);
    chk("t3_wdata1", d_s_wdata[63:32], 32'h55);
    chk("t3_adr1", d_s_adr[63:32], 32'h1000_0004);
    chk("t3_wdata0", d_s_wdata[31:0], 0);
    s_ack = 3'b010;
    #1;
    chk("t3_ack1", d_m_ack, 2'b10);
    tick();
    s_ack = '0; m_cyc = '0; m_stb = '0; m_we = '0;
    tick();

    // Unmapped address
    m_cyc = 2'b01; m_stb = 2'b01; m_adr = 64'h3000_0000;
    tick();
    chk("t4_busy", d_busy, 1);
    chk("t4_no_stb", d_s_stb, 0);
    chk("t4_no_cyc", d_s_cyc, 0);
    chk("t4_no_err_yet", d_m_err, 0);
    tick();
    chk("t4_err", d_m_err, 2'b01);
    chk("t4_no_ack", d_m_ack, 0);
    chk("t4_rdata", d_m_rdata, 0);
    tick();
    chk("t4_err_pulse", d_m_err, 0);
    chk("t4_gnt_held", d_gnt_id, 0);
    chk("t4_busy_held", d_busy, 1);
    m_stb = 2'b00;
    tick();
    chk("t4_err_quiet", d_m_err, 0);
    chk("t4_lock", d_busy, 1);
    m_cyc = 2'b00;
    tick();
    chk("t4_release", d_busy, 0);

    // Timeout on debug slave that never acks
    m_cyc = 2'b01; m_stb = 2'b01; m_adr = 64'h2000_0000;
    tick();
    chk("t5_s_stb", d_s_stb, 3'b100);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 7; c++) begin
        tick();
        chk("t5_no_err", d_m_err, 0);
      end
      tick();
      chk("t5_err", d_m_err, 2'b01);
      if (p == 0) begin
        tick();
        m_stb = 2'b00;
        tick();
        tick();
        m_stb = 2'b01;
      end
    end
    m_cyc = '0; m_stb = '0;
    tick();
    tick();

    // Asynchronous reset during outstanding read
    m_cyc = 2'b01; m_stb = 2'b01; m_adr = 64'h10;
    tick();
    chk("t6_s_stb", d_s_stb, 3'b001);
    s_ack = 3'b001; s_rdata[31:0] = 32'hCAFE_F00D;
    #1;
    chk("t6_ack", d_m_ack, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_s_cyc", d_s_cyc, 0);
    chk("t6_s_stb0", d_s_stb, 0);
    chk("t6_s_adr", d_s_adr, 0);
    chk("t6_m_ack", d_m_ack, 0);
    chk("t6_m_rdata", d_m_rdata, 0);
    chk("t6_busy", d_busy, 0);
    chk("t6_rr_busy", r_busy, 0);
    s_ack = '0; m_cyc = 2'b11; m_stb = 2'b11;
    #1 rst_n = 1'b1;
    #1;
    chk("t6_post_busy", d_busy, 0);
    tick();
    chk("t6_rr_ptr0", r_gnt_id, 0);
    chk("t6_fix_gnt", d_gnt_id, 0);
    chk("t6_rr_busy1", r_busy, 1);
    m_cyc = '0; m_stb = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
